// File: rtl/csr_port_arbiter_pkg.sv
// Shared types and constants for the CSR port arbiter: FSM states, owner tag, well-known CSR addresses.
package csr_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INS  = 1'b0,
        OWN_TRAP = 1'b1
    } owner_e;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;

endpackage

// File: rtl/csr_port_arbiter.sv
// Arbitrates the single CSR-file port between the trap sequencer and the instruction CSR path.
// Optional saturating statistics counters are enabled with CSR_ARB_STATS_EN.
//
// state      | meaning
// IDLE       | fixed priority trap > instruction; trap_req & trap_lock enters LOCKED
// LOCKED     | trap-only port; watchdog counts cycles, forced release to RECOVER
// RECOVER    | arbitrates like IDLE, ignores trap_lock until it drops
module csr_port_arbiter
    import csr_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 8
`ifdef CSR_ARB_STATS_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trap_req,
    input  logic              trap_lock,
    input  logic              trap_we,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic [DATA_W-1:0] trap_wdata,
    output logic              trap_gnt,
    output logic              trap_rvalid,
    input  logic              ins_req,
    input  logic              ins_we,
    input  logic [ADDR_W-1:0] ins_addr,
    input  logic [DATA_W-1:0] ins_wdata,
    output logic              ins_gnt,
    output logic              ins_stall,
    output logic              ins_rvalid,
    output logic              csr_en,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [DATA_W-1:0] csr_wdata,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              lock_err
`ifdef CSR_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_conflict,
    output logic [CNT_W-1:0]  stat_timeout
`endif
);

    localparam int LCW = $clog2(LOCK_TIMEOUT);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);

    arb_state_e     state_q, state_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    owner_e         owner_q, owner_d;
    logic           rvalid_q, rvalid_d;
    logic           lock_err_q, lock_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            owner_q    <= OWN_INS;
            rvalid_q   <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            owner_q    <= owner_d;
            rvalid_q   <= rvalid_d;
            lock_err_q <= lock_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
        lock_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_req && trap_lock) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                // A voluntary release on the last allowed cycle is not an error.
                if (!trap_lock) begin
                    state_d = ST_IDLE;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_RECOVER;
                    lock_err_d = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (!trap_lock) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grants are gated by rst_n so nothing reaches the CSR file while reset is held.
    always_comb begin
        trap_gnt  = rst_n & trap_req;
        ins_gnt   = rst_n & ins_req & ~trap_req & (state_q != ST_LOCKED);
        ins_stall = ins_req & ~ins_gnt;
        csr_en    = trap_gnt | ins_gnt;
        csr_we    = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;
        if (trap_gnt) begin
            csr_we    = trap_we;
            csr_addr  = trap_addr;
            csr_wdata = trap_wdata;
        end else if (ins_gnt) begin
            csr_we    = ins_we;
            csr_addr  = ins_addr;
            csr_wdata = ins_wdata;
        end
        owner_d     = trap_gnt ? OWN_TRAP : OWN_INS;
        rvalid_d    = csr_en;
        trap_rvalid = rvalid_q & (owner_q == OWN_TRAP);
        ins_rvalid  = rvalid_q & (owner_q == OWN_INS);
        rdata       = rvalid_q ? csr_rdata : '0;
        lock_err    = lock_err_q;
    end

`ifdef CSR_ARB_STATS_EN
    logic [CNT_W-1:0] conflict_q, conflict_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;

    always_comb begin
        conflict_d = conflict_q;
        timeout_d  = timeout_q;
        if (ins_stall && !(&conflict_q)) conflict_d = conflict_q + 1'b1;
        if (lock_err_q && !(&timeout_q)) timeout_d = timeout_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
            timeout_q  <= '0;
        end else begin
            conflict_q <= conflict_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stat_conflict = conflict_q;
    assign stat_timeout  = timeout_q;
`endif

endmodule
